// File: rtl/poci_key_sw_input_if.sv
// POCI register-bus bundle between the HASTI-to-POCI bridge and a peripheral slave.
interface poci_key_sw_input_if;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/poci_key_sw_input.sv
// Pushbutton / toggle-switch input block: synchronise, debounce, sticky edge flags,
// key-press level interrupt, all exposed as POCI registers.
module poci_key_sw_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    poci_key_sw_input_if.slave      bus,
    input  logic [3:0]              key_n,
    input  logic [9:0]              sw,
    output logic                    irq
);

    localparam int unsigned N_KEY = 4;
    localparam int unsigned N_SW  = 10;
    localparam int unsigned N_IN  = N_KEY + N_SW;

    localparam logic [7:0] OFF_KEY_STATE  = 8'h00;
    localparam logic [7:0] OFF_KEY_EDGE   = 8'h04;
    localparam logic [7:0] OFF_KEY_IRQ_EN = 8'h08;
    localparam logic [7:0] OFF_SW_STATE   = 8'h10;
    localparam logic [7:0] OFF_SW_EDGE    = 8'h14;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEY-1:0] key_s1, key_s2;
    logic [N_SW-1:0]  sw_s1, sw_s2;
    logic [N_IN-1:0]  in_sync;
    logic [N_IN-1:0]  deb_state;
    logic [N_IN-1:0]  differ;
    logic [N_IN-1:0]  settle;
    logic [CNT_W-1:0] cnt [N_IN];

    logic [N_KEY-1:0] key_state;
    logic [N_SW-1:0]  sw_state;
    logic [N_KEY-1:0] key_edge;
    logic [N_SW-1:0]  sw_edge;
    logic [N_KEY-1:0] key_irq_en;
    logic [N_KEY-1:0] key_set, key_clr;
    logic [N_SW-1:0]  sw_set, sw_clr;

    logic        access;
    logic        wr_en;
    logic        mapped;
    logic [31:0] rdata;
    logic        unused_pwdata;

    // Two-flop synchronisers; keys idle high (released) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    assign in_sync   = {sw_s2, ~key_s2};
    assign key_state = deb_state[N_KEY-1:0];
    assign sw_state  = deb_state[N_IN-1:N_KEY];

    always_comb begin
        differ = '0;
        settle = '0;
        for (int i = 0; i < N_IN; i++) begin
            differ[i] = in_sync[i] ^ deb_state[i];
            settle[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit debounce: any cycle agreeing with the current state restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_state <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (!differ[i] || settle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (settle[i]) begin
                    deb_state[i] <= in_sync[i];
                end
            end
        end
    end

    assign key_set = settle[N_KEY-1:0] & in_sync[N_KEY-1:0];
    assign sw_set  = settle[N_IN-1:N_KEY];

    assign access  = bus.psel & bus.penable;
    assign wr_en   = access & bus.pwrite;
    assign key_clr = (wr_en && (bus.paddr == OFF_KEY_EDGE)) ? bus.pwdata[N_KEY-1:0] : '0;
    assign sw_clr  = (wr_en && (bus.paddr == OFF_SW_EDGE))  ? bus.pwdata[N_SW-1:0]  : '0;

    // Sticky flags: a new edge outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_edge   <= '0;
            sw_edge    <= '0;
            key_irq_en <= '0;
            irq        <= 1'b0;
        end else begin
            key_edge <= (key_edge & ~key_clr) | key_set;
            sw_edge  <= (sw_edge  & ~sw_clr)  | sw_set;
            if (wr_en && (bus.paddr == OFF_KEY_IRQ_EN)) begin
                key_irq_en <= bus.pwdata[N_KEY-1:0];
            end
            irq <= |(key_edge & key_irq_en);
        end
    end

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (bus.paddr)
            OFF_KEY_STATE:  rdata = 32'(key_state);
            OFF_KEY_EDGE:   rdata = 32'(key_edge);
            OFF_KEY_IRQ_EN: rdata = 32'(key_irq_en);
            OFF_SW_STATE:   rdata = 32'(sw_state);
            OFF_SW_EDGE:    rdata = 32'(sw_edge);
            default:        mapped = 1'b0;
        endcase
    end

    assign bus.prdata  = (access && !bus.pwrite && mapped) ? rdata : '0;
    assign bus.pslverr = access & ~mapped;
    assign bus.pready  = 1'b1;

    assign unused_pwdata = ^bus.pwdata[31:N_SW];

endmodule

// File: tb/tb_poci_key_sw_input.sv
// Directed bench for poci_key_sw_input with a short debounce window.
module tb_poci_key_sw_input;

    localparam int unsigned DB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poci_key_sw_input_if bus ();

    poci_key_sw_input #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .key_n (key_n),
        .sw    (sw),
        .irq   (irq)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int unsigned N_VEC = 16;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full POCI transfer; prdata/pslverr are sampled inside the access phase.
    task automatic bus_access(input logic [7:0] a, input logic w, input logic [31:0] d,
                              output logic [31:0] rd, output logic err);
        @(negedge clk);
        bus.paddr   = a;
        bus.pwrite  = w;
        bus.pwdata  = d;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        rd  = bus.prdata;
        err = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        bus_access(a, 1'b0, 32'h0, rd, err);
        check(name, rd, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        err;
        bus_access(a, 1'b1, d, rd, err);
        check("wr_pslverr", 32'(err), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        vecs[0]  = '{8'h00, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[1]  = '{8'h04, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{8'h08, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{8'h10, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{8'h14, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[5]  = '{8'h08, 1'b1, 32'hFFFF_FFFA, 32'h0, 1'b0};
        vecs[6]  = '{8'h08, 1'b0, 32'h0,        32'hA, 1'b0};
        vecs[7]  = '{8'h00, 1'b1, 32'hF,        32'h0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[9]  = '{8'h20, 1'b0, 32'h0,        32'h0, 1'b1};
        vecs[10] = '{8'h20, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[11] = '{8'h08, 1'b0, 32'h0,        32'hA, 1'b0};
        vecs[12] = '{8'h08, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[13] = '{8'h0C, 1'b0, 32'h0,        32'h0, 1'b1};
        vecs[14] = '{8'h10, 1'b1, 32'h3FF,      32'h0, 1'b0};
        vecs[15] = '{8'h10, 1'b0, 32'h0,        32'h0, 1'b0};

        reset       = 1'b1;
        key_n       = 4'hF;
        sw          = 10'h0;
        bus.paddr   = 8'h0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.pwdata  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_pready", 32'(bus.pready), 32'h1);
        check("reset_prdata", bus.prdata, 32'h0);
        reset = 1'b0;

        // Register map, RO/RW behaviour and unmapped offsets
        for (int i = 0; i < N_VEC; i++) begin
            bus_access(vecs[i].addr, vecs[i].write, vecs[i].wdata, rd, err);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
        end
        check("table_irq", 32'(irq), 32'h0);

        // Key 2 press: state updates exactly 2 + DB edges after the raw change
        @(negedge clk);
        key_n = 4'b1011;
        repeat (DB + 1) @(posedge clk);
        @(negedge clk);
        check("key2_before", 32'(dut.key_state), 32'h0);
        @(negedge clk);
        check("key2_after", 32'(dut.key_state), 32'h4);
        rd_chk("key2_edge_rd", 8'h04, 32'h4);
        rd_chk("key2_state_rd", 8'h00, 32'h4);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        check("key2_released", 32'(dut.key_state), 32'h0);
        rd_chk("key2_edge_sticky", 8'h04, 32'h4);
        wr(8'h04, 32'h4);
        rd_chk("key2_edge_clr", 8'h04, 32'h0);

        // Switch 5: a 10-cycle pulse is rejected
        sw = 10'h020;
        repeat (10) @(negedge clk);
        sw = 10'h000;
        repeat (DB + 6) @(negedge clk);
        check("sw5_glitch_state", 32'(dut.sw_state), 32'h0);
        rd_chk("sw5_glitch_edge", 8'h14, 32'h0);

        // Switch 5: one-cycle dropout restarts the count, then a stable high settles
        sw = 10'h020;
        repeat (12) @(negedge clk);
        sw = 10'h000;
        @(negedge clk);
        sw = 10'h020;
        repeat (DB + 1) @(posedge clk);
        @(negedge clk);
        check("sw5_before", 32'(dut.sw_state), 32'h0);
        @(negedge clk);
        check("sw5_after", 32'(dut.sw_state), 32'h020);
        rd_chk("sw5_edge_rd", 8'h14, 32'h020);
        rd_chk("sw5_state_rd", 8'h10, 32'h020);
        wr(8'h14, 32'h020);
        rd_chk("sw5_edge_clr", 8'h14, 32'h0);

        // Interrupt follows masked key flags by one cycle
        wr(8'h08, 32'h1);
        key_n = 4'b1110;
        repeat (DB + 1) @(posedge clk);
        @(negedge clk);
        check("irq_flag_before", 32'(dut.key_edge), 32'h0);
        @(negedge clk);
        check("irq_flag_set", 32'(dut.key_edge), 32'h1);
        check("irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_high", 32'(irq), 32'h1);
        wr(8'h04, 32'h1);
        check("irq_flag_clr", 32'(dut.key_edge), 32'h0);
        check("irq_still_high", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_low", 32'(irq), 32'h0);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);

        // Masked: key 1 press sets its flag but no interrupt
        wr(8'h08, 32'h0);
        key_n = 4'b1101;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < DB + 8; c++) begin
                @(negedge clk);
                seen = seen | irq;
            end
            check("irq_masked", 32'(seen), 32'h0);
        end
        rd_chk("masked_edge_rd", 8'h04, 32'h2);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        wr(8'h04, 32'h2);
        rd_chk("masked_edge_clr", 8'h04, 32'h0);

        // W1C lands on the same edge as a new key 0 press: set wins
        @(negedge clk);
        key_n = 4'b1110;
        repeat (DB) @(negedge clk);
        bus.paddr   = 8'h04;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        check("race_state", 32'(dut.key_state), 32'h1);
        check("race_edge", 32'(dut.key_edge), 32'h1);

        // Reset mid-debounce and mid-write
        wr(8'h08, 32'h5);
        key_n = 4'b0110;
        sw    = 10'h220;
        repeat (10) @(negedge clk);
        check("pre_reset_cnt", 32'(dut.cnt[3] != '0), 32'h1);
        bus.paddr   = 8'h08;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'hF;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        reset       = 1'b1;
        #1;
        check("rst_key_state", 32'(dut.key_state), 32'h0);
        check("rst_sw_state", 32'(dut.sw_state), 32'h0);
        check("rst_cnt_key3", 32'(dut.cnt[3]), 32'h0);
        check("rst_cnt_sw9", 32'(dut.cnt[13]), 32'h0);
        check("rst_key_edge", 32'(dut.key_edge), 32'h0);
        check("rst_sw_edge", 32'(dut.sw_edge), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        reset       = 1'b0;
        rd_chk("rst_irq_en_rd", 8'h08, 32'h0);
        rd_chk("rst_key_edge_rd", 8'h04, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
